stv_elastic_buffer: RTL and testbench

// - Parametrised N-entry ready/valid elastic buffer; successor of the 2-entry skid stage.
// - Cuts every path: valid_out, ready_out and data_out are each driven directly by a flop.
// - Sustains 1 transfer/cycle with DEPTH entries of slack for long-wire retiming.
// - Adds synchronous flush for pipeline kill/redirect.
//

---
 rtl/stv_elastic_buffer.sv | 96 +++++++++
 tb/tb_stv_elastic_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stv_elastic_buffer.sv
// N-entry ready/valid elastic buffer: flopped head register plus a (DEPTH-1)-entry circular FIFO.
// Optional occupancy port level_out is enabled by defining STV_ELASTIC_BUFFER_LEVEL_EN.
module stv_elastic_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out
`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_out
`endif
);

    localparam int FD  = DEPTH - 1;
    localparam int PW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int FDM = (FD < 2) ? 2 : FD;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             valid_q, ready_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] mem_q [FDM];

    logic push, pop;
    logic head_from_in, head_from_fifo, fifo_wr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push           = valid_in & ready_q;
        pop            = valid_q & ready_in;
        // An empty buffer, or one whose only beat is leaving, bypasses the FIFO.
        head_from_in   = push & ((count_q == '0) | ((count_q == CW'(1)) & pop));
        fifo_wr        = push & ~head_from_in;
        head_from_fifo = pop & (count_q > CW'(1));
        count_d        = count_q + CW'(push) - CW'(pop);
        wr_ptr_d       = fifo_wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = head_from_fifo ? next_ptr(rd_ptr_q) : rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= (count_d != '0);
            ready_q  <= (count_d != CW'(DEPTH));
        end
    end

    // Payload storage is intentionally unreset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (head_from_in) begin
                head_q <= data_in;
            end else if (head_from_fifo) begin
                head_q <= mem_q[rd_ptr_q];
            end
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end
    end

    assign valid_out = valid_q;
    assign ready_out = ready_q;
    assign data_out  = head_q;

`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
    assign level_out = count_q;
`endif

endmodule

// File: tb/tb_stv_elastic_buffer.sv
// Bench for stv_elastic_buffer: DEPTH=4 instance against a queue model, DEPTH=2 instance with directed vectors.
`timescale 1ns/1ps
module tb_stv_elastic_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       flush = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic       ready_in = 1'b0;
    logic       ready_out, valid_out;
    logic [7:0] data_out;

    logic       flush2 = 1'b0;
    logic       valid2 = 1'b0;
    logic [7:0] data2 = '0;
    logic       ready2 = 1'b0;
    logic       ready_out2, valid_out2;
    logic [7:0] data_out2;

`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
    logic [2:0] level_out;
    logic [1:0] level_out2;
`endif

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int pushes   = 0;
    logic [7:0] exp_q[$];

    stv_elastic_buffer #(.WIDTH(8), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out)
`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
        ,
        .level_out (level_out)
`endif
    );

    stv_elastic_buffer #(.WIDTH(8), .DEPTH(2)) u_dut2 (
        .clk       (clk),
        .arst_n    (arst_n),
        .flush     (flush2),
        .valid_in  (valid2),
        .ready_out (ready_out2),
        .data_in   (data2),
        .ready_in  (ready2),
        .valid_out (valid_out2),
        .data_out  (data_out2)
`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
        ,
        .level_out (level_out2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; applies inputs for one cycle, updates the model, checks after the next edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f,
                        output logic acc);
        logic       push, pop, hold;
        logic [7:0] held;
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        push = v & ready_out;
        pop  = valid_out & r;
        hold = valid_out & ~r & ~f;
        held = data_out;
        acc  = push & ~f;
        if (f) begin
            exp_q.delete();
        end else begin
            if (pop && exp_q.size() > 0) begin
                check_eq("pop_data", {24'h0, data_out}, {24'h0, exp_q[0]});
                void'(exp_q.pop_front());
                pops++;
            end
            if (push) begin
                exp_q.push_back(d);
                pushes++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("valid_out", {31'h0, valid_out}, {31'h0, exp_q.size() != 0});
        check_eq("ready_out", {31'h0, ready_out}, {31'h0, exp_q.size() != DEPTH});
        if (hold) check_eq("hold_data", {24'h0, data_out}, {24'h0, held});
`ifdef STV_ELASTIC_BUFFER_LEVEL_EN
        check_eq("level_out", {29'h0, level_out}, exp_q.size());
`endif
    endtask

    task automatic cyc2();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       acc;
        logic       v;
        logic [7:0] d;
        logic       pend;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'h0, valid_out}, 32'h0);
        check_eq("rst_ready", {31'h0, ready_out}, 32'h1);
        check_eq("rst_valid2", {31'h0, valid_out2}, 32'h0);
        check_eq("rst_ready2", {31'h0, ready_out2}, 32'h1);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through: 100 back-to-back beats, one-cycle latency
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, acc);
            check_eq("pt_accept", {31'h0, acc}, 32'h1);
            check_eq("pt_valid", {31'h0, valid_out}, 32'h1);
            check_eq("pt_data", {24'h0, data_out}, i);
        end
        step(1'b0, 8'h0, 1'b1, 1'b0, acc);
        step(1'b0, 8'h0, 1'b1, 1'b0, acc);
        check_eq("pt_pops", pops, 100);

        // Fill to full with target stalled
        step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA2, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA3, 1'b0, 1'b0, acc);
        step(1'b1, 8'hA4, 1'b0, 1'b0, acc);
        check_eq("fill_ready", {31'h0, ready_out}, 32'h0);
        check_eq("fill_head", {24'h0, data_out}, 32'hA1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        check_eq("full_no_accept", {31'h0, acc}, 32'h0);

        // Drain one from full
        step(1'b0, 8'h0, 1'b1, 1'b0, acc);
        check_eq("drain_head", {24'h0, data_out}, 32'hA2);
        check_eq("drain_ready", {31'h0, ready_out}, 32'h1);

        // Flush at count=3 while pushing and popping
        step(1'b1, 8'hEE, 1'b1, 1'b1, acc);
        check_eq("flush_valid", {31'h0, valid_out}, 32'h0);
        check_eq("flush_ready", {31'h0, ready_out}, 32'h1);
        step(1'b1, 8'h55, 1'b1, 1'b0, acc);
        check_eq("post_flush_head", {24'h0, data_out}, 32'h55);
        step(1'b0, 8'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-burst at count=2
        step(1'b1, 8'h61, 1'b0, 1'b0, acc);
        step(1'b1, 8'h62, 1'b0, 1'b0, acc);
        valid_in = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'h0, valid_out}, 32'h0);
        check_eq("arst_ready", {31'h0, ready_out}, 32'h1);
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h71, 1'b1, 1'b0, acc);
        check_eq("resume_head", {24'h0, data_out}, 32'h71);
        step(1'b1, 8'h72, 1'b1, 1'b0, acc);
        check_eq("resume_next", {24'h0, data_out}, 32'h72);
        step(1'b0, 8'h0, 1'b1, 1'b0, acc);

        // Random valid/ready with initiator holding data until accepted
        pushes = 0;
        pops   = 0;
        pend   = 1'b0;
        d      = 8'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                v = 1'($urandom_range(0, 1));
                if (v) d = d + 8'h1;
            end else begin
                v = 1'b1;
            end
            step(v, d, 1'($urandom_range(0, 1)), 1'b0, acc);
            pend = v & ~acc;
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h0, 1'b1, 1'b0, acc);
        check_eq("rand_balance", pops, pushes);
        check_eq("rand_empty", {31'h0, valid_out}, 32'h0);

        // DEPTH=2 instance: fill, full, drain, push+pop at count=1
        valid2 = 1'b1; data2 = 8'h11; ready2 = 1'b0;
        cyc2();
        check_eq("d2_valid1", {31'h0, valid_out2}, 32'h1);
        check_eq("d2_data1", {24'h0, data_out2}, 32'h11);
        data2 = 8'h22;
        cyc2();
        check_eq("d2_full", {31'h0, ready_out2}, 32'h0);
        check_eq("d2_head", {24'h0, data_out2}, 32'h11);
        valid2 = 1'b0; ready2 = 1'b1;
        cyc2();
        check_eq("d2_pop_data", {24'h0, data_out2}, 32'h22);
        check_eq("d2_reopen", {31'h0, ready_out2}, 32'h1);
        valid2 = 1'b1; data2 = 8'h33;
        cyc2();
        check_eq("d2_pushpop_data", {24'h0, data_out2}, 32'h33);
        check_eq("d2_pushpop_valid", {31'h0, valid_out2}, 32'h1);
        check_eq("d2_pushpop_ready", {31'h0, ready_out2}, 32'h1);
        valid2 = 1'b0;
        cyc2();
        check_eq("d2_empty", {31'h0, valid_out2}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
